fp_round_stage: RTL and testbench

//   Post-processing stage downstream of the FP sqrt/arith units: consumes an

---
 rtl/fp_pkg.sv | 66 ++++++
 rtl/fp_round_core.sv | 80 ++++++++
 rtl/fp_round_stage.sv | 130 +++++++++++++
 tb/tb_fp_round_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point types: formats, rounding modes, unrounded results, flags.
package fp_pkg;

   typedef enum logic [1:0] {
      FP32 = 2'd0,
      FP64 = 2'd1,
      FP16 = 2'd2
   } fp_format_e;

   function automatic int unsigned exp_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 11;
         FP16:    return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 52;
         FP16:    return 10;
         default: return 23;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e fmt);
      return 1 + exp_bits(fmt) + man_bits(fmt);
   endfunction

   localparam fp_format_e  FP_FORMAT_DEF = FP32;
   localparam int unsigned FP_WIDTH      = fp_width(FP_FORMAT_DEF);
   localparam int unsigned EXP_WIDTH     = exp_bits(FP_FORMAT_DEF);
   localparam int unsigned MANT_WIDTH    = man_bits(FP_FORMAT_DEF);

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } roundmode_e;

   typedef struct packed {
      logic                  sign;
      logic [EXP_WIDTH-1:0]  exponent;
      logic [MANT_WIDTH-1:0] mantissa;
   } fp_encoding_t;

   // rs = {round, sticky}; exp_cout = {tiny, exponent overflow}
   typedef struct packed {
      logic [FP_WIDTH-1:0] u_result;
      logic [1:0]          rs;
      logic                round_en;
      logic                invalid;
      logic [1:0]          exp_cout;
   } uround_res_t;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

endpackage

// File: rtl/fp_round_core.sv
// Combinational rounding: increment decision, overflow saturation and exception flags.
module fp_round_core
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0]   u_result_i,
   input  logic [1:0]             rs_i,
   input  logic                   round_en_i,
   input  logic                   invalid_i,
   input  logic [1:0]             exp_cout_i,
   input  roundmode_e             rnd_i,
   output logic [EXP_W+MAN_W:0]   result_c_o,
   output fflags_t                fflags_c_o
);

   localparam int unsigned EM_W = EXP_W + MAN_W;

   logic             sign;
   logic             lsb;
   logic             rbit;
   logic             sbit;
   logic             inc;
   logic             of;
   logic             nx;
   logic             to_inf;
   logic [EM_W-1:0]  em_sum;
   logic [EXP_W-1:0] exp_post;

   always_comb begin
      sign   = u_result_i[EM_W];
      lsb    = u_result_i[0];
      rbit   = rs_i[1];
      sbit   = rs_i[0];
      inc    = 1'b0;
      to_inf = 1'b1;
      // Unlisted mode codes fall back to round-to-nearest-even
      case (rnd_i)
         RTZ: begin
            inc    = 1'b0;
            to_inf = 1'b0;
         end
         RDN: begin
            inc    = sign & (rbit | sbit);
            to_inf = sign;
         end
         RUP: begin
            inc    = ~sign & (rbit | sbit);
            to_inf = ~sign;
         end
         RMM: inc = rbit;
         default: inc = rbit & (sbit | lsb);
      endcase

      // Mantissa carry ripples straight into the exponent field
      em_sum   = u_result_i[EM_W-1:0] + EM_W'(inc);
      exp_post = em_sum[EM_W-1:MAN_W];
      of       = round_en_i & ((&exp_post) | exp_cout_i[0]);
      nx       = round_en_i & (rbit | sbit | of);

      result_c_o = u_result_i;
      if (round_en_i) begin
         result_c_o = {sign, em_sum};
         if (of) begin
            if (to_inf)
               result_c_o = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
               result_c_o = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         end
      end

      fflags_c_o.nv = invalid_i;
      fflags_c_o.dz = 1'b0;
      fflags_c_o.of = of;
      fflags_c_o.uf = round_en_i & exp_cout_i[1] & nx;
      fflags_c_o.nx = nx;
   end

endmodule

// File: rtl/fp_round_stage.sv
// Rounding output stage: rounds on accept and buffers results in an output reg plus skid reg.
module fp_round_stage
   import fp_pkg::*;
#(
   parameter fp_format_e FP_FORMAT = FP32
) (
   input  logic                             clk_i,
   input  logic                             reset_ni,
   input  logic                             valid_i,
   output logic                             ready_o,
   input  uround_res_t                      urnd_i,
   input  roundmode_e                       rnd_i,
   input  logic                             kill_i,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [fp_width(FP_FORMAT)-1:0]   result_o,
   output logic [4:0]                       fflags_o
);

   localparam int unsigned FP_W = fp_width(FP_FORMAT);
   localparam int unsigned EXP_W = exp_bits(FP_FORMAT);
   localparam int unsigned MAN_W = man_bits(FP_FORMAT);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   buf_state_e       state_q, state_d;
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;
   logic [FP_W-1:0]  res_q, res_d;
   fflags_t          flg_q, flg_d;
   logic [FP_W-1:0]  skid_res_q, skid_res_d;
   fflags_t          skid_flg_q, skid_flg_d;
   logic [FP_W-1:0]  rnd_res_c;
   fflags_t          rnd_flg_c;
   logic             in_xfer;
   logic             out_xfer;

   fp_round_core #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_core (
      .u_result_i (urnd_i.u_result),
      .rs_i       (urnd_i.rs),
      .round_en_i (urnd_i.round_en),
      .invalid_i  (urnd_i.invalid),
      .exp_cout_i (urnd_i.exp_cout),
      .rnd_i      (rnd_i),
      .result_c_o (rnd_res_c),
      .fflags_c_o (rnd_flg_c)
   );

   // Buffer next-state and register load selection
   always_comb begin
      state_d    = state_q;
      res_d      = res_q;
      flg_d      = flg_q;
      skid_res_d = skid_res_q;
      skid_flg_d = skid_flg_q;
      in_xfer    = valid_i & ready_q;
      out_xfer   = valid_q & ready_i;

      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               res_d   = rnd_res_c;
               flg_d   = rnd_flg_c;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               res_d = rnd_res_c;
               flg_d = rnd_flg_c;
            end else if (in_xfer) begin
               skid_res_d = rnd_res_c;
               skid_flg_d = rnd_flg_c;
               state_d    = FULL;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               res_d   = skid_res_q;
               flg_d   = skid_flg_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (kill_i)
         state_d = EMPTY;

      valid_d = (state_d != EMPTY);
      ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

   // Skid contents are only observed after being moved into the output reg
   always_ff @(posedge clk_i) begin
      skid_res_q <= skid_res_d;
      skid_flg_q <= skid_flg_d;
   end

   assign valid_o  = valid_q;
   assign ready_o  = ready_q;
   assign result_o = res_q;
   assign fflags_o = 5'(flg_q);

endmodule

// File: tb/tb_fp_round_stage.sv
// Directed bench for fp_round_stage: rounding vectors, skid buffering, kill and async reset.
module tb_fp_round_stage;
   import fp_pkg::*;

   logic        clk_i;
   logic        reset_ni;
   logic        valid_i;
   logic        ready_o;
   uround_res_t urnd_i;
   roundmode_e  rnd_i;
   logic        kill_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic [4:0]  fflags_o;

   int checks;
   int errors;

   fp_round_stage #(.FP_FORMAT(FP32)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .urnd_i   (urnd_i),
      .rnd_i    (rnd_i),
      .kill_i   (kill_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o),
      .fflags_o (fflags_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Present one beat for one accept edge, then sample the registered result
   task automatic apply(input logic [31:0] u, input logic [1:0] rs, input logic en,
                        input logic inv, input logic [1:0] cout, input roundmode_e m);
      urnd_i.u_result = u;
      urnd_i.rs       = rs;
      urnd_i.round_en = en;
      urnd_i.invalid  = inv;
      urnd_i.exp_cout = cout;
      rnd_i           = m;
      valid_i         = 1'b1;
      ready_i         = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_hs: valid_o=%b ready_o=%b want 0/1", valid_o, ready_o);
      end
      checks++;
      if (result_o !== 32'h0 || fflags_o !== 5'h00) begin
         errors++;
         $display("FAIL reset_data: result=%h flags=%h want 00000000/00", result_o, fflags_o);
      end
   endtask

   task automatic test_rne();
      apply(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RNE);
      checks++;
      if (valid_o !== 1'b1 || result_o !== 32'h3F800000 || fflags_o !== 5'h01) begin
         errors++;
         $display("FAIL rne_tie_even: v=%b result=%h flags=%h want 1/3F800000/01", valid_o, result_o, fflags_o);
      end
      apply(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, RNE);
      checks++;
      if (result_o !== 32'h3F800001 || fflags_o !== 5'h01) begin
         errors++;
         $display("FAIL rne_up: result=%h flags=%h want 3F800001/01", result_o, fflags_o);
      end
      apply(32'h3F800000, 2'b00, 1'b1, 1'b0, 2'b00, RNE);
      checks++;
      if (result_o !== 32'h3F800000 || fflags_o !== 5'h00) begin
         errors++;
         $display("FAIL rne_exact: result=%h flags=%h want 3F800000/00", result_o, fflags_o);
      end
      apply(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, roundmode_e'(3'b101));
      checks++;
      if (result_o !== 32'h3F800001 || fflags_o !== 5'h01) begin
         errors++;
         $display("FAIL mode101_as_rne: result=%h flags=%h want 3F800001/01", result_o, fflags_o);
      end
   endtask

   task automatic test_overflow();
      apply(32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b01, RNE);
      checks++;
      if (result_o !== 32'h7F800000 || fflags_o !== 5'h05) begin
         errors++;
         $display("FAIL of_rne_inf: result=%h flags=%h want 7F800000/05", result_o, fflags_o);
      end
      apply(32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b01, RTZ);
      checks++;
      if (result_o !== 32'h7F7FFFFF || fflags_o !== 5'h05) begin
         errors++;
         $display("FAIL of_rtz_max: result=%h flags=%h want 7F7FFFFF/05", result_o, fflags_o);
      end
      apply(32'hFF7FFFFF, 2'b10, 1'b1, 1'b0, 2'b01, RDN);
      checks++;
      if (result_o !== 32'hFF800000 || fflags_o !== 5'h05) begin
         errors++;
         $display("FAIL of_rdn_neg_inf: result=%h flags=%h want FF800000/05", result_o, fflags_o);
      end
      // Increment alone carries the exponent to all ones, no exp_cout
      apply(32'h7F7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00, RUP);
      checks++;
      if (result_o !== 32'h7F800000 || fflags_o !== 5'h05) begin
         errors++;
         $display("FAIL of_rup_carry: result=%h flags=%h want 7F800000/05", result_o, fflags_o);
      end
   endtask

   task automatic test_directed_modes();
      apply(32'h3F7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00, RUP);
      checks++;
      if (result_o !== 32'h3F800000 || fflags_o !== 5'h01) begin
         errors++;
         $display("FAIL rup_exp_carry: result=%h flags=%h want 3F800000/01", result_o, fflags_o);
      end
      apply(32'h3F7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00, RDN);
      checks++;
      if (result_o !== 32'h3F7FFFFF || fflags_o !== 5'h01) begin
         errors++;
         $display("FAIL rdn_pos: result=%h flags=%h want 3F7FFFFF/01", result_o, fflags_o);
      end
      apply(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM);
      checks++;
      if (result_o !== 32'h3F800001 || fflags_o !== 5'h01) begin
         errors++;
         $display("FAIL rmm_tie: result=%h flags=%h want 3F800001/01", result_o, fflags_o);
      end
      apply(32'h00000001, 2'b01, 1'b1, 1'b0, 2'b10, RNE);
      checks++;
      if (result_o !== 32'h00000001 || fflags_o !== 5'h03) begin
         errors++;
         $display("FAIL uf_tiny_inexact: result=%h flags=%h want 00000001/03", result_o, fflags_o);
      end
   endtask

   task automatic test_passthrough();
      apply(32'h7FC00000, 2'b11, 1'b0, 1'b1, 2'b11, RNE);
      checks++;
      if (result_o !== 32'h7FC00000 || fflags_o !== 5'h10) begin
         errors++;
         $display("FAIL bypass_invalid: result=%h flags=%h want 7FC00000/10", result_o, fflags_o);
      end
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: valid_o=%b want 0", valid_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] beats [4];
      logic [31:0] seen  [4];
      int   sent;
      int   got;
      logic win;
      logic wout;
      beats[0] = 32'h11111111;
      beats[1] = 32'h22222222;
      beats[2] = 32'h33333333;
      beats[3] = 32'h44444444;
      seen[0] = '0; seen[1] = '0; seen[2] = '0; seen[3] = '0;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         ready_i         = (cyc >= 3);
         valid_i         = (sent < 4);
         urnd_i.u_result = beats[(sent < 4) ? sent : 3];
         urnd_i.rs       = 2'b11;
         urnd_i.round_en = 1'b0;
         urnd_i.invalid  = 1'b0;
         urnd_i.exp_cout = 2'b00;
         rnd_i           = RNE;
         win  = valid_i & ready_o;
         wout = valid_o & ready_i;
         if (wout && got < 4) begin
            seen[got] = result_o;
            got++;
         end
         @(posedge clk_i);
         #1;
         if (win) sent++;
         if (cyc == 0) begin
            checks++;
            if (ready_o !== 1'b1) begin
               errors++;
               $display("FAIL ready_after_1st: ready_o=%b want 1", ready_o);
            end
         end
         if (cyc == 1) begin
            checks++;
            if (ready_o !== 1'b0) begin
               errors++;
               $display("FAIL ready_after_2nd: ready_o=%b want 0", ready_o);
            end
         end
      end
      valid_i = 1'b0;
      checks++;
      if (got != 4) begin
         errors++;
         $display("FAIL drain_count: got %0d beats want 4", got);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (seen[i] !== beats[i]) begin
            errors++;
            $display("FAIL order_%0d: result=%h want %h", i, seen[i], beats[i]);
         end
      end
   endtask

   task automatic test_kill();
      ready_i         = 1'b0;
      urnd_i.round_en = 1'b0;
      urnd_i.u_result = 32'hAAAA0001;
      valid_i         = 1'b1;
      @(posedge clk_i);
      #1;
      urnd_i.u_result = 32'hAAAA0002;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL kill_prefill: ready_o=%b valid_o=%b want 0/1", ready_o, valid_o);
      end
      kill_i = 1'b1;
      @(posedge clk_i);
      #1;
      kill_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL kill_flush: valid_o=%b ready_o=%b want 0/1", valid_o, ready_o);
      end
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("FAIL kill_no_resurrect: valid_o=%b want 0", valid_o);
      end
   endtask

   task automatic test_async_reset();
      apply(32'h3F800000, 2'b11, 1'b1, 1'b1, 2'b00, RNE);
      ready_i = 1'b0;
      #2;
      reset_ni = 1'b0;
      #1;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'h0 || fflags_o !== 5'h00) begin
         errors++;
         $display("FAIL async_reset: v=%b r=%b result=%h flags=%h want 0/1/00000000/00",
                  valid_o, ready_o, result_o, fflags_o);
      end
      @(negedge clk_i);
      reset_ni = 1'b1;
      @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_idle: v=%b r=%b want 0/1", valid_o, ready_o);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset_ni        = 1'b0;
      valid_i         = 1'b0;
      ready_i         = 1'b0;
      kill_i          = 1'b0;
      rnd_i           = RNE;
      urnd_i          = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_ni = 1'b1;
      @(posedge clk_i);
      #1;
      test_reset();
      test_rne();
      test_overflow();
      test_directed_modes();
      test_passthrough();
      test_back_to_back();
      test_kill();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
